// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: resource-side controller for a combinational round-robin arbiter.
// It drives the arbiter's one-hot base and latches one owner from the arbiter's
// one-hot grant. It then runs a valid/ready handshake with the shared resource
// and keeps ownership until the owner drops its request. On release, base moves
// to the position just after the owner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   req        request vector (also feeds the arbiter)
//   grant_in   one-hot grant from the arbiter
//   base       one-hot base to the arbiter
//   owner      one-hot current owner, zero when idle
//   owner_idx  binary index of owner, zero when idle
//   busy       high while an owner is latched (GRANT/HOLD)
//   res_valid  request to the shared resource (GRANT only)
//   res_ready  resource accepts the owner
//   grant_err  one-cycle pulse on an illegal grant_in
//   timeout    one-cycle pulse on forced release
//
// Optional feature: define RRC_TIMEOUT_EN to bound HOLD to HOLD_LIMIT cycles.
// Without it, timeout is tied low and HOLD is unbounded.
module rr_grant_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned IDXW       = 2,
  parameter int unsigned HOLD_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] grant_in,
  output logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] owner,
  output logic [IDXW-1:0]  owner_idx,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             grant_err,
  output logic             timeout
);

  if (WIDTH < 2 || IDXW != $clog2(WIDTH) || HOLD_LIMIT < 1) begin : g_param_check
    $error("rr_grant_ctrl: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] base_n, owner_n;
  logic [IDXW-1:0]  idx_n, grant_idx;
  logic             busy_n, rv_n, err_n;
  logic             grant_legal, owner_req, hold_expired;

  // The grant must be exactly one-hot and must only select a requester.
  assign grant_legal = (grant_in != '0) &&
                       ((grant_in & (grant_in - ONE)) == '0) &&
                       ((grant_in & ~req) == '0);

  assign owner_req = req[owner_idx];

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (grant_in[i]) grant_idx = IDXW'(i);
    end
  end

`ifdef RRC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_LIMIT + 1);

  logic [CW-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == CW'(HOLD_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state == GRANT) hold_cnt <= '0;
      else if (state == HOLD) hold_cnt <= hold_cnt + CW'(1);
      // A normal release in the same cycle wins, so timeout needs owner_req.
      timeout <= (state == HOLD) && owner_req && hold_expired;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_n = state;
    base_n  = base;
    owner_n = owner;
    idx_n   = owner_idx;
    busy_n  = busy;
    rv_n    = res_valid;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          if (grant_legal) begin
            state_n = GRANT;
            owner_n = grant_in;
            idx_n   = grant_idx;
            busy_n  = 1'b1;
            rv_n    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      GRANT: begin
        // Acceptance takes priority over a same-cycle withdrawal.
        if (res_valid && res_ready) begin
          state_n = HOLD;
          rv_n    = 1'b0;
        end else if (!owner_req) begin
          state_n = IDLE;
          owner_n = '0;
          idx_n   = '0;
          busy_n  = 1'b0;
          rv_n    = 1'b0;
        end
      end
      HOLD: begin
        if (!owner_req || hold_expired) begin
          state_n = IDLE;
          base_n  = {owner[WIDTH-2:0], owner[WIDTH-1]};
          owner_n = '0;
          idx_n   = '0;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        owner_n = '0;
        idx_n   = '0;
        busy_n  = 1'b0;
        rv_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= ONE;
      owner     <= '0;
      owner_idx <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      state     <= state_n;
      base      <= base_n;
      owner     <= owner_n;
      owner_idx <= idx_n;
      busy      <= busy_n;
      res_valid <= rv_n;
      grant_err <= err_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl. An abstract integer-level reference
// model predicts the registered outputs for every stimulus cycle. A monitor
// compares those predictions against the DUT. The directed scenarios come
// first, and a randomized phase follows. It honours RRC_TIMEOUT_EN in the
// same way the design does.
module tb_rr_grant_ctrl;

  localparam int W  = 4;
  localparam int HL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] req = '0;
  logic [W-1:0] grant_in = '0;
  logic         res_ready = 1'b0;
  logic [W-1:0] base, owner;
  logic [1:0]   owner_idx;
  logic         busy, res_valid, grant_err, timeout;

  rr_grant_ctrl #(.WIDTH(W), .IDXW(2), .HOLD_LIMIT(HL)) dut (
    .clk(clk), .rst(rst), .req(req), .grant_in(grant_in), .base(base),
    .owner(owner), .owner_idx(owner_idx), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .grant_err(grant_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] owner;
    logic [1:0]   idx;
    logic [W-1:0] base;
    logic         busy;
    logic         rv;
    logic         err;
    logic         to;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner as an integer (-1 = none), base as a position.
  int m_own  = -1;
  bit m_acc  = 1'b0;
  int m_base = 0;
  int m_hold = 0;
  bit m_err  = 1'b0;
  bit m_to   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] onehot(input int p);
    logic [W-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Round-robin arbiter as seen by the controller: first request at or after base.
  function automatic logic [W-1:0] arb(input logic [W-1:0] r);
    for (int k = 0; k < W; k++) begin
      if (r[(m_base + k) % W]) return onehot((m_base + k) % W);
    end
    return '0;
  endfunction

  function automatic exp_t m_outputs();
    exp_t e;
    e.owner = (m_own >= 0) ? onehot(m_own) : '0;
    e.idx   = (m_own >= 0) ? 2'(m_own) : 2'd0;
    e.base  = onehot(m_base);
    e.busy  = (m_own >= 0);
    e.rv    = (m_own >= 0) && !m_acc;
    e.err   = m_err;
    e.to    = m_to;
    return e;
  endfunction

  task automatic model_reset();
    m_own = -1; m_acc = 1'b0; m_base = 0; m_hold = 0; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic [W-1:0] g, input logic rdy);
    int holder;
    m_err = 1'b0;
    m_to  = 1'b0;
    if (m_own < 0) begin
      if (r != '0) begin
        if ($countones(g) == 1 && (g & ~r) == '0) begin
          for (int i = 0; i < W; i++) if (g[i]) holder = i;
          m_own = holder;
          m_acc = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (!m_acc) begin
      if (rdy) begin
        m_acc  = 1'b1;
        m_hold = 0;
      end else if (!r[m_own]) begin
        m_own = -1;
      end
    end else begin
      if (!r[m_own]) begin
        m_base = (m_own + 1) % W;
        m_own  = -1;
`ifdef RRC_TIMEOUT_EN
      end else if (m_hold == HL - 1) begin
        m_base = (m_own + 1) % W;
        m_own  = -1;
        m_to   = 1'b1;
`endif
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic cycle(input logic [W-1:0] r, input logic [W-1:0] g, input logic rdy);
    @(negedge clk);
    req       = r;
    grant_in  = g;
    res_ready = rdy;
    model_step(r, g, rdy);
    q.push_back(m_outputs());
    @(posedge clk);
    #2;
  endtask

  // Monitor: every registered output is compared against the prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("sb_owner",     32'(owner),     32'(mon_e.owner));
        chk("sb_owner_idx", 32'(owner_idx), 32'(mon_e.idx));
        chk("sb_base",      32'(base),      32'(mon_e.base));
        chk("sb_busy",      32'(busy),      32'(mon_e.busy));
        chk("sb_res_valid", 32'(res_valid), 32'(mon_e.rv));
        chk("sb_grant_err", 32'(grant_err), 32'(mon_e.err));
        chk("sb_timeout",   32'(timeout),   32'(mon_e.to));
      end
    end
  end

  logic [W-1:0] cur;
  logic [W-1:0] g;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_base",  32'(base),  32'h1);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_rv",    32'(res_valid), 32'h0);
    chk("rst_err",   32'(grant_err), 32'h0);
    chk("rst_to",    32'(timeout),   32'h0);
    rst = 1'b0;

    // Basic cycle: grant, accept, release.
    cycle(4'b0010, arb(4'b0010), 1'b0);
    chk("basic_owner", 32'(owner), 32'b0010);
    chk("basic_idx",   32'(owner_idx), 32'd1);
    chk("basic_rv",    32'(res_valid), 32'h1);
    cycle(4'b0010, 4'b0000, 1'b1);
    chk("basic_hold_rv",   32'(res_valid), 32'h0);
    chk("basic_hold_busy", 32'(busy), 32'h1);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("basic_base",  32'(base),  32'b0100);
    chk("basic_idle",  32'(owner), 32'h0);

    // Wrap from the top requester back to bit 0.
    cycle(4'b1000, arb(4'b1000), 1'b0);
    cycle(4'b1000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("wrap_base", 32'(base), 32'b0001);
    cycle(4'b1001, arb(4'b1001), 1'b0);
    chk("wrap_owner", 32'(owner), 32'b0001);
    cycle(4'b1001, 4'b0000, 1'b1);
    cycle(4'b1000, 4'b0000, 1'b0);
    chk("wrap_rel_base", 32'(base), 32'b0010);

    // Withdraw before acceptance: base must not move.
    cycle(4'b0100, arb(4'b0100), 1'b0);
    chk("wd_owner", 32'(owner), 32'b0100);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("wd_idle",  32'(owner), 32'h0);
    chk("wd_base",  32'(base),  32'b0010);
    chk("wd_busy",  32'(busy),  32'h0);

    // Illegal grant: error pulse for one cycle only.
    cycle(4'b0011, 4'b0110, 1'b0);
    chk("ill_err",  32'(grant_err), 32'h1);
    chk("ill_busy", 32'(busy), 32'h0);
    chk("ill_base", 32'(base), 32'b0010);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("ill_err_clr", 32'(grant_err), 32'h0);

    // Persistent owner: forced release when enabled, unbounded otherwise.
    cycle(4'b0001, 4'b0001, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b1);
    repeat (3) begin
      cycle(4'b0001, 4'b0000, 1'b0);
      chk("hold_busy", 32'(busy), 32'h1);
      chk("hold_to",   32'(timeout), 32'h0);
    end
    cycle(4'b0001, 4'b0000, 1'b0);
`ifdef RRC_TIMEOUT_EN
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_busy",  32'(busy),    32'h0);
    chk("to_base",  32'(base),    32'b0010);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("to_pulse_end", 32'(timeout), 32'h0);
`else
    chk("nto_busy", 32'(busy), 32'h1);
    chk("nto_to",   32'(timeout), 32'h0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("nto_base", 32'(base), 32'b0010);
`endif

    // Asynchronous reset in the middle of HOLD.
    cycle(4'b0100, 4'b0100, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1);
    chk("prerst_owner", 32'(owner), 32'b0100);
    #1;
    rst = 1'b1;
    req = '0;
    grant_in = '0;
    res_ready = 1'b0;
    #1;
    chk("arst_owner", 32'(owner), 32'h0);
    chk("arst_busy",  32'(busy),  32'h0);
    chk("arst_base",  32'(base),  32'b0001);
    chk("arst_rv",    32'(res_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic: sticky requests, mostly-correct arbiter, random ready.
    cur = '0;
    repeat (600) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
      end
      if ($urandom_range(0, 9) == 0) g = W'($urandom);
      else g = arb(cur);
      cycle(cur, g, 1'($urandom_range(0, 1)));
    end

    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
